// File: rtl/pipeline_hazard_controller_if.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller_if
//
// Bundles the hazard-detection inputs and the latch/PC control outputs of the
// pipeline hazard controller.
//
//   master : hazard sources (drives hazard inputs, observes controls)
//   slave  : the hazard controller itself
//
// Hazard inputs : mem_req, dcache_ready, icache_ready, load_use_hazard,
//                 id_redirect, ex_redirect, halt_id, halt_wb
// Controls      : stall_{ifid,idex,exmem,memwb}, flush_{ifid,idex,exmem,memwb},
//                 pc_write_en, pc_src[1:0], halted
// Counters      : stall_cycles, flush_events, dmiss_events (CNT_WIDTH each)
// -----------------------------------------------------------------------------
interface pipeline_hazard_controller_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 mem_req;
  logic                 dcache_ready;
  logic                 icache_ready;
  logic                 load_use_hazard;
  logic                 id_redirect;
  logic                 ex_redirect;
  logic                 halt_id;
  logic                 halt_wb;

  logic                 stall_ifid;
  logic                 stall_idex;
  logic                 stall_exmem;
  logic                 stall_memwb;
  logic                 flush_ifid;
  logic                 flush_idex;
  logic                 flush_exmem;
  logic                 flush_memwb;
  logic                 pc_write_en;
  logic [1:0]           pc_src;
  logic                 halted;
  logic [CNT_WIDTH-1:0] stall_cycles;
  logic [CNT_WIDTH-1:0] flush_events;
  logic [CNT_WIDTH-1:0] dmiss_events;

  modport master (
    output mem_req, dcache_ready, icache_ready, load_use_hazard,
           id_redirect, ex_redirect, halt_id, halt_wb,
    input  stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           pc_write_en, pc_src, halted,
           stall_cycles, flush_events, dmiss_events
  );

  modport slave (
    input  mem_req, dcache_ready, icache_ready, load_use_hazard,
           id_redirect, ex_redirect, halt_id, halt_wb,
    output stall_ifid, stall_idex, stall_exmem, stall_memwb,
           flush_ifid, flush_idex, flush_exmem, flush_memwb,
           pc_write_en, pc_src, halted,
           stall_cycles, flush_events, dmiss_events
  );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// pipeline_hazard_controller
//
// Central stall/flush sequencer for the cached 5-stage pipeline. Resolves
// data/instruction cache waits, load-use hazards, ID jumps, EX mispredicts and
// halt draining by fixed priority, and keeps saturating performance counters.
//
// Ports:
//   clk      : clock
//   reset_n  : synchronous, active-low reset
//   hz       : slave side of pipeline_hazard_controller_if (hazard inputs,
//              latch stall/flush controls, PC control, halted, counters)
//
// All latch/PC controls are combinational from the registered mode/discard
// state and the current hazard inputs; state and counters update at posedge.
// -----------------------------------------------------------------------------
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  pipeline_hazard_controller_if.slave   hz
);

  typedef enum logic [1:0] {
    MODE_RUN    = 2'd0,
    MODE_DRAIN  = 2'd1,
    MODE_HALTED = 2'd2
  } mode_e;

  localparam logic [1:0] PC_SEQ = 2'b00;
  localparam logic [1:0] PC_ID  = 2'b01;
  localparam logic [1:0] PC_EX  = 2'b10;

  mode_e                mode_q, mode_d;
  logic                 discard_q, discard_d;
  logic                 mem_wait_q;
  logic [CNT_WIDTH-1:0] stall_cnt_q, flush_cnt_q, dmiss_cnt_q;

  logic       mem_busy;
  logic       stall_ifid, stall_idex, stall_exmem, stall_memwb;
  logic       flush_ifid, flush_idex, flush_exmem, flush_memwb;
  logic       pc_write_en;
  logic [1:0] pc_src;
  logic       halted;
  logic       redirect_fired;   // rule 2 or rule 4 fired this cycle

  assign mem_busy = hz.mem_req & ~hz.dcache_ready;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    stall_ifid     = 1'b0;
    stall_idex     = 1'b0;
    stall_exmem    = 1'b0;
    stall_memwb    = 1'b0;
    flush_ifid     = 1'b0;
    flush_idex     = 1'b0;
    flush_exmem    = 1'b0;
    flush_memwb    = 1'b0;
    pc_write_en    = 1'b0;
    pc_src         = PC_SEQ;
    halted         = 1'b0;
    redirect_fired = 1'b0;
    mode_d         = mode_q;
    discard_d      = discard_q;

    if (!reset_n) begin
      // Controls stay quiet while reset is held; state is cleared at the edge.
    end else if (mode_q == MODE_HALTED) begin
      stall_ifid  = 1'b1;
      stall_idex  = 1'b1;
      stall_exmem = 1'b1;
      stall_memwb = 1'b1;
      halted      = 1'b1;
    end else begin
      if (mem_busy) begin
        // Redirects and halt_id are ignored: EX and ID re-present them once
        // the memory stage frees up.
        stall_ifid  = 1'b1;
        stall_idex  = 1'b1;
        stall_exmem = 1'b1;
        flush_memwb = 1'b1;
      end else if (hz.ex_redirect) begin
        flush_ifid     = 1'b1;
        flush_idex     = 1'b1;
        pc_src         = PC_EX;
        pc_write_en    = 1'b1;
        redirect_fired = 1'b1;
        if (!hz.icache_ready) discard_d = 1'b1;
        // A halt seen in ID behind a mispredict was wrong-path.
        if (mode_q == MODE_DRAIN) mode_d = MODE_RUN;
      end else if (hz.load_use_hazard) begin
        stall_ifid = 1'b1;
        flush_idex = 1'b1;
      end else begin
        if (hz.id_redirect && (mode_q == MODE_RUN)) begin
          flush_ifid     = 1'b1;
          pc_src         = PC_ID;
          pc_write_en    = 1'b1;
          redirect_fired = 1'b1;
          if (!hz.icache_ready) discard_d = 1'b1;
        end else if ((mode_q == MODE_DRAIN) || !hz.icache_ready || discard_q) begin
          // Bubble IF/ID; a returning wrong-path fetch is dropped here, which
          // costs exactly one cycle when icache_ready comes back.
          flush_ifid = 1'b1;
          if (hz.icache_ready) discard_d = 1'b0;
        end else begin
          pc_write_en = 1'b1;
        end

        if ((mode_q == MODE_RUN) && hz.halt_id) begin
          mode_d     = MODE_DRAIN;
          flush_ifid = 1'b1;
        end
      end

      if (hz.halt_wb) mode_d = MODE_HALTED;
    end
  end

  // NOTE: reset is sampled only on the clock edge (synchronous); the
  // combinational block above additionally forces the outputs low meanwhile.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mode_q      <= MODE_RUN;
      discard_q   <= 1'b0;
      mem_wait_q  <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      dmiss_cnt_q <= '0;
    end else begin
      mode_q     <= mode_d;
      discard_q  <= discard_d;
      mem_wait_q <= mem_busy;
      if ((mode_q != MODE_HALTED) && !pc_write_en) stall_cnt_q <= sat_inc(stall_cnt_q);
      if (redirect_fired)                          flush_cnt_q <= sat_inc(flush_cnt_q);
      // Only the first cycle of a multi-cycle miss counts.
      if (mem_busy && !mem_wait_q)                 dmiss_cnt_q <= sat_inc(dmiss_cnt_q);
    end
  end

  assign hz.stall_ifid   = stall_ifid;
  assign hz.stall_idex   = stall_idex;
  assign hz.stall_exmem  = stall_exmem;
  assign hz.stall_memwb  = stall_memwb;
  assign hz.flush_ifid   = flush_ifid;
  assign hz.flush_idex   = flush_idex;
  assign hz.flush_exmem  = flush_exmem;
  assign hz.flush_memwb  = flush_memwb;
  assign hz.pc_write_en  = pc_write_en;
  assign hz.pc_src       = pc_src;
  assign hz.halted       = halted;
  assign hz.stall_cycles = stall_cnt_q;
  assign hz.flush_events = flush_cnt_q;
  assign hz.dmiss_events = dmiss_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// -----------------------------------------------------------------------------
// tb_pipeline_hazard_controller
//
// Directed bench for pipeline_hazard_controller. Inputs change on the falling
// edge; each step pushes its expected controls or counter values into a
// scoreboard queue, and the front entry is popped and compared 1 ns later,
// away from the rising edge at which the DUT samples.
// -----------------------------------------------------------------------------
module tb_pipeline_hazard_controller;

  localparam int CW = 16;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  pipeline_hazard_controller_if #(.CNT_WIDTH(CW)) hz ();

  pipeline_hazard_controller #(.CNT_WIDTH(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (hz)
  );

  typedef struct packed {
    logic mem_req;
    logic dcache_ready;
    logic icache_ready;
    logic load_use;
    logic id_redir;
    logic ex_redir;
    logic halt_id;
    logic halt_wb;
  } in_t;

  // {stall ifid,idex,exmem,memwb}, {flush ...}, pc_write_en, pc_src, halted
  typedef struct {
    string       tag;
    bit          is_cnt;
    logic [47:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic in_t idle();
    in_t i;
    i = '0;
    i.dcache_ready = 1'b1;
    i.icache_ready = 1'b1;
    return i;
  endfunction

  function automatic logic [47:0] ctl(input logic [3:0] st, input logic [3:0] fl,
                                      input logic we, input logic [1:0] src,
                                      input logic h);
    return {36'd0, st, fl, we, src, h};
  endfunction

  function automatic logic [47:0] cntv(input int s, input int f, input int d);
    return {CW'(s), CW'(f), CW'(d)};
  endfunction

  task automatic apply(input in_t i);
    hz.mem_req         = i.mem_req;
    hz.dcache_ready    = i.dcache_ready;
    hz.icache_ready    = i.icache_ready;
    hz.load_use_hazard = i.load_use;
    hz.id_redirect     = i.id_redir;
    hz.ex_redirect     = i.ex_redir;
    hz.halt_id         = i.halt_id;
    hz.halt_wb         = i.halt_wb;
  endtask

  task automatic compare_front();
    exp_t        e;
    logic [47:0] obs;
    n_checks++;
    if (sb.size() == 0) begin
      n_errors++;
      $error("FAIL scoreboard_empty: observed no entry, expected one");
    end else begin
      e = sb.pop_front();
      if (e.is_cnt)
        obs = {hz.stall_cycles, hz.flush_events, hz.dmiss_events};
      else
        obs = {36'd0, hz.stall_ifid, hz.stall_idex, hz.stall_exmem, hz.stall_memwb,
               hz.flush_ifid, hz.flush_idex, hz.flush_exmem, hz.flush_memwb,
               hz.pc_write_en, hz.pc_src, hz.halted};
      assert (obs === e.val) else begin
        n_errors++;
        $error("FAIL %s: observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  // One clock cycle: drive inputs, check combinational controls, advance.
  task automatic cyc(input string tag, input in_t i, input logic [47:0] exp_ctl);
    apply(i);
    sb.push_back('{tag: tag, is_cnt: 1'b0, val: exp_ctl});
    #1;
    compare_front();
    @(negedge clk);
  endtask

  // Counter values reflect all edges seen so far; no time advances.
  task automatic cnt(input string tag, input int s, input int f, input int d);
    sb.push_back('{tag: tag, is_cnt: 1'b1, val: cntv(s, f, d)});
    #1;
    compare_front();
  endtask

  logic [47:0] normal, dmiss, zero_out, halted_out, fetch_bubble;
  in_t         i;

  initial begin
    normal       = ctl(4'b0000, 4'b0000, 1'b1, 2'b00, 1'b0);
    dmiss        = ctl(4'b1110, 4'b0001, 1'b0, 2'b00, 1'b0);
    zero_out     = ctl(4'b0000, 4'b0000, 1'b0, 2'b00, 1'b0);
    halted_out   = ctl(4'b1111, 4'b0000, 1'b0, 2'b00, 1'b1);
    fetch_bubble = ctl(4'b0000, 4'b1000, 1'b0, 2'b00, 1'b0);

    // Reset: outputs forced low while reset_n=0.
    reset_n = 1'b0;
    cyc("reset_out0", idle(), zero_out);
    cyc("reset_out1", idle(), zero_out);
    cnt("reset_cnt", 0, 0, 0);
    reset_n = 1'b1;

    cyc("normal", idle(), normal);

    // Data miss for 3 cycles, ex_redirect ignored on the first.
    i = idle(); i.mem_req = 1'b1; i.dcache_ready = 1'b0; i.ex_redir = 1'b1;
    cyc("dmiss_c1_redir_ignored", i, dmiss);
    i.ex_redir = 1'b0;
    cyc("dmiss_c2", i, dmiss);
    cyc("dmiss_c3", i, dmiss);
    cyc("dmiss_done", idle(), normal);
    cnt("dmiss_cnt", 3, 0, 1);

    // Load-use beats a simultaneous ID jump; jump taken next cycle.
    i = idle(); i.load_use = 1'b1; i.id_redir = 1'b1;
    cyc("loaduse_over_idredir", i, ctl(4'b1000, 4'b0100, 1'b0, 2'b00, 1'b0));
    i = idle(); i.id_redir = 1'b1;
    cyc("idredir", i, ctl(4'b0000, 4'b1000, 1'b1, 2'b01, 1'b0));
    cyc("after_idredir", idle(), normal);
    cnt("loaduse_cnt", 4, 1, 1);

    // EX mispredict while the icache is waiting: one extra bubble on return.
    i = idle(); i.ex_redir = 1'b1; i.icache_ready = 1'b0;
    cyc("exredir_imiss", i, ctl(4'b0000, 4'b1100, 1'b1, 2'b10, 1'b0));
    i = idle(); i.icache_ready = 1'b0;
    cyc("imiss_wait1", i, fetch_bubble);
    cyc("imiss_wait2", i, fetch_bubble);
    cyc("discard_bubble", idle(), fetch_bubble);
    cyc("fetch_resumes", idle(), normal);
    cnt("discard_cnt", 7, 2, 1);

    // Wrong-path halt: DRAIN then ex_redirect returns to RUN.
    i = idle(); i.halt_id = 1'b1;
    cyc("wp_halt_enter", i, ctl(4'b0000, 4'b1000, 1'b1, 2'b00, 1'b0));
    i = idle(); i.ex_redir = 1'b1;
    cyc("wp_exredir", i, ctl(4'b0000, 4'b1100, 1'b1, 2'b10, 1'b0));
    cyc("wp_back_in_run", idle(), normal);
    cyc("wp_still_run", idle(), normal);
    cnt("wp_cnt", 7, 3, 1);

    // Real halt: DRAIN bubbles, id_redirect ignored in DRAIN, halt_wb 3 later.
    i = idle(); i.halt_id = 1'b1;
    cyc("halt_enter", i, ctl(4'b0000, 4'b1000, 1'b1, 2'b00, 1'b0));
    cyc("drain1", idle(), fetch_bubble);
    i = idle(); i.id_redir = 1'b1;
    cyc("drain2_idredir_ignored", i, fetch_bubble);
    i = idle(); i.halt_wb = 1'b1;
    cyc("drain3_halt_wb", i, fetch_bubble);
    cyc("halted1", idle(), halted_out);
    i = idle(); i.ex_redir = 1'b1; i.halt_id = 1'b1;
    cyc("halted2_inputs_ignored", i, halted_out);
    cyc("halted3", idle(), halted_out);
    cnt("halt_cnt", 10, 3, 1);

    // Reset out of HALTED.
    reset_n = 1'b0;
    cyc("reset_from_halt", idle(), zero_out);
    cnt("reset_from_halt_cnt", 0, 0, 0);
    reset_n = 1'b1;
    cyc("run_after_reset", idle(), normal);

    // Saturation: a 70000-cycle miss.
    i = idle(); i.mem_req = 1'b1; i.dcache_ready = 1'b0;
    cyc("sat_first", i, dmiss);
    repeat (69999) @(negedge clk);
    cnt("sat_cnt", 'hFFFF, 0, 1);
    cyc("sat_still_stalled", i, dmiss);
    cnt("sat_hold", 'hFFFF, 0, 1);

    reset_n = 1'b0;
    cyc("sat_reset_out", idle(), zero_out);
    cnt("sat_reset_cnt", 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
# pipeline_hazard_controller

Central stall/flush sequencer for the cached 5-stage TSC pipeline; drives the stall and flush inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB latches plus the PC write enable and PC source select. Resolves data-cache and instruction-cache waits, load-use hazards, ID-stage jumps, EX-stage mispredicts and halt draining by fixed priority. It tracks wrong-path fetch discard and halt state in registers, and keeps saturating performance counters.

## Interface
- CNT_WIDTH, 16, width of each performance counter
- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- mem_req  in  1  EX/MEM latch holds a load/store
- dcache_ready  in  1  data cache completes the MEM access this cycle
- icache_ready  in  1  instruction cache returns the fetch this cycle
- load_use_hazard  in  1  ID instruction depends on a load in EX
- id_redirect  in  1  jump resolved in ID, target on PC mux input 1
- ex_redirect  in  1  branch mispredict resolved in EX, target on PC mux input 2
- halt_id  in  1  HLT decoded in ID
- halt_wb  in  1  HLT in WB
- stall_ifid, stall_idex, stall_exmem, stall_memwb  out  1 each  hold latch
- flush_ifid, flush_idex, flush_exmem, flush_memwb  out  1 each  load bubble into latch
- pc_write_en  out  1  PC register update enable
- pc_src  out  2  00 sequential, 01 ID target, 10 EX target
- halted  out  1  core halted
- stall_cycles, flush_events, dmiss_events  out  CNT_WIDTH each  counters

## Operation
- Registered state: mode in {RUN, DRAIN, HALTED}, discard flag, mem_wait flag, three counters.
- mem_busy = mem_req & ~dcache_ready. All outputs are combinational from state and inputs. Per cycle, the first matching rule applies in RUN and DRAIN:
  1. mem_busy: stall PC, IFID, IDEX, EXMEM; flush MEMWB. Redirects and halt_id are ignored, because the EX and ID instructions re-present them next cycle.
  2. ex_redirect: flush IFID and IDEX; pc_src=10; pc_write_en=1. Set discard if ~icache_ready. In DRAIN, return to RUN because the halt was wrong-path.
  3. load_use_hazard: stall PC and IFID; flush IDEX.
  4. id_redirect (RUN only): flush IFID; pc_src=01; pc_write_en=1. Set discard if ~icache_ready.
  5. DRAIN, or ~icache_ready, or (discard & icache_ready): stall PC; flush IFID. Clear discard when icache_ready=1.
  6. Otherwise: pc_write_en=1, pc_src=00, no stalls, no flushes.
- Transitions:
  - RUN to DRAIN: halt_id while rules 1–3 do not fire. This is applied after the rule 4–6 outputs, and IFID is flushed.
  - DRAIN to HALTED: halt_wb.
  - Any mode to HALTED: halt_wb.
  - HALTED is left only by reset.
- HALTED outputs: all four stalls 1, all flushes 0, pc_write_en=0, halted=1.
- Counters, all saturating at all-ones with no wrap:
  - stall_cycles: +1 each non-HALTED cycle with pc_write_en=0.
  - flush_events: +1 each cycle rule 2 or rule 4 fires.
  - dmiss_events: +1 on a cycle where mem_busy=1 and mem_wait=0. mem_wait is set to mem_busy at the clock edge, so a multi-cycle miss counts once.
- Rules 1–6 apply in RUN and DRAIN. The only DRAIN-specific behaviour is rule 4 being inactive and rule 5 always firing.

## Timing
- Stall, flush, PC and halted outputs are zero-latency combinational, valid before the posedge at which the latches sample them.
- Mode, discard, mem_wait and counters update at posedge clk.
- Reset: on a posedge with reset_n=0, mode=RUN, discard=0, mem_wait=0, counters=0.
- While reset_n=0, outputs are forced: all stalls 0, flushes 0, pc_write_en=0, pc_src=00, halted=0.
- A reset mid-miss or mid-drain discards all state.
- halted rises the cycle after the edge at which halt_wb is sampled.
- A discarded fetch costs exactly one extra bubble cycle, on the cycle icache_ready returns.

## Test plan
- Data miss: mem_req=1, dcache_ready=0 for 3 cycles. Required: 3 cycles of stall_ifid/idex/exmem=1, flush_memwb=1, pc_write_en=0; dmiss_events=1; stall_cycles=3.
- Load-use with a simultaneous id_redirect: stall_ifid=1, flush_idex=1, pc_write_en=0, flush_ifid=0. Next cycle, with the hazard cleared: pc_src=01, flush_ifid=1, flush_events=1.
- ex_redirect during an icache wait (icache_ready=0):
  - Redirect cycle: flush_ifid=flush_idex=1, pc_src=10.
  - Wait cycles: IFID bubbles.
  - First cycle icache_ready=1: flush_ifid=1, pc_write_en=0.
  - Following cycle: normal fetch with pc_write_en=1.
- Halt sequence: halt_id, then halt_wb 3 cycles later. Required: flush_ifid=1 every DRAIN cycle; halted=1 from the cycle after halt_wb; all stalls=1 until reset.
- Wrong-path halt: halt_id enters DRAIN, then ex_redirect next cycle. Required: mode returns to RUN and pc_src=10; a later halt_wb-free run keeps halted=0.
- Saturation: force 70000 stall cycles with CNT_WIDTH=16. Required: stall_cycles=0xFFFF, and 0x0000 one cycle after reset_n=0.
